// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, FSM state type and match helper for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        MWAIT = 1'b1
    } state_t;

    // Producer/consumer match; register 0 is hardwired and never matches.
    function automatic logic reg_hit(input logic       we,
                                     input logic [4:0] dst,
                                     input logic [4:0] src);
        return we && (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Combinational forwarding-select generation for the Decode comparator and Execute operands.
module pipe_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_rs_d,
    input  logic [4:0] i_rt_d,
    input  logic [4:0] i_rs_e,
    input  logic [4:0] i_rt_e,
    input  logic [4:0] i_write_reg_m,
    input  logic [4:0] i_write_reg_w,
    input  logic       i_reg_write_m,
    input  logic       i_reg_write_w,
    output logic       o_fwd_ad,
    output logic       o_fwd_bd,
    output logic [1:0] o_fwd_ae,
    output logic [1:0] o_fwd_be
);

    always_comb begin
        o_fwd_ae = FWD_RF;
        if (reg_hit(i_reg_write_m, i_write_reg_m, i_rs_e))
            o_fwd_ae = FWD_MEM;
        else if (reg_hit(i_reg_write_w, i_write_reg_w, i_rs_e))
            o_fwd_ae = FWD_WB;

        o_fwd_be = FWD_RF;
        if (reg_hit(i_reg_write_m, i_write_reg_m, i_rt_e))
            o_fwd_be = FWD_MEM;
        else if (reg_hit(i_reg_write_w, i_write_reg_w, i_rt_e))
            o_fwd_be = FWD_WB;

        o_fwd_ad = reg_hit(i_reg_write_m, i_write_reg_m, i_rs_d);
        o_fwd_bd = reg_hit(i_reg_write_m, i_write_reg_m, i_rt_d);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline with a memory wait-state FSM and timeout.
// Optional HAZ_PERF_EN adds saturating stall-cycle and flush counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       MemtoRegM,
    input  logic       BranchD,
    input  logic       PCSrcD,
    input  logic       MemAccessM,
    input  logic       mem_ready,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
`ifdef HAZ_PERF_EN
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush_cnt,
`endif
    output logic       mem_err
);

    state_t           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_mem_err;

    logic       w_fwd_ad;
    logic       w_fwd_bd;
    logic [1:0] w_fwd_ae;
    logic [1:0] w_fwd_be;
    logic       w_lwstall;
    logic       w_brstall;
    logic       w_tmo;
    logic       w_memstall;

    pipe_fwd_unit u_fwd (
        .i_rs_d        (RsD),
        .i_rt_d        (RtD),
        .i_rs_e        (RsE),
        .i_rt_e        (RtE),
        .i_write_reg_m (WriteRegM),
        .i_write_reg_w (WriteRegW),
        .i_reg_write_m (RegWriteM),
        .i_reg_write_w (RegWriteW),
        .o_fwd_ad      (w_fwd_ad),
        .o_fwd_bd      (w_fwd_bd),
        .o_fwd_ae      (w_fwd_ae),
        .o_fwd_be      (w_fwd_be)
    );

    assign w_lwstall  = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
    assign w_brstall  = BranchD &&
                        (reg_hit(RegWriteE, WriteRegE, RsD) || reg_hit(RegWriteE, WriteRegE, RtD) ||
                         reg_hit(MemtoRegM, WriteRegM, RsD) || reg_hit(MemtoRegM, WriteRegM, RtD));
    assign w_tmo      = (r_state == MWAIT) && (r_wait_cnt == CNT_W'(MEM_TIMEOUT));
    assign w_memstall = MemAccessM && !mem_ready && !w_tmo;

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (!rst) begin
            ForwardAD = w_fwd_ad;
            ForwardBD = w_fwd_bd;
            ForwardAE = w_fwd_ae;
            ForwardBE = w_fwd_be;
            if (w_memstall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (w_tmo) begin
                // Aborted access must not reach the register file.
                FlushW = 1'b1;
            end else if (w_lwstall || w_brstall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end else if (PCSrcD) begin
                FlushD = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_memstall) begin
                        r_state    <= MWAIT;
                        r_wait_cnt <= CNT_W'(1);
                    end else begin
                        r_wait_cnt <= '0;
                    end
                end
                MWAIT: begin
                    if (!MemAccessM || mem_ready) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else if (w_tmo) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                        r_mem_err  <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    assign mem_err = r_mem_err;

`ifdef HAZ_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (StallF && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 32'd1;
            if ((FlushD || FlushE) && (r_perf_flush != '1))
                r_perf_flush <= r_perf_flush + 32'd1;
        end
    end

    assign perf_stall_cyc = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected output vectors are queued per cycle and
// compared mid-cycle. Build with HAZ_PERF_EN defined to also cover the perf counters.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic       BranchD, PCSrcD, MemAccessM, mem_ready;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic       ForwardAD, ForwardBD, mem_err;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZ_PERF_EN
    logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .PCSrcD(PCSrcD), .MemAccessM(MemAccessM), .mem_ready(mem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
`ifdef HAZ_PERF_EN
        .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt),
`endif
        .mem_err(mem_err)
    );

    // {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushW, AD,BD, AE[1:0], BE[1:0], mem_err}
    logic [13:0] obs;
    assign obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                  ForwardAD, ForwardBD, ForwardAE, ForwardBE, mem_err};

    typedef struct {
        logic [13:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    localparam logic [3:0] S_NONE = 4'b0000;
    localparam logic [3:0] S_ALL  = 4'b1111;
    localparam logic [3:0] S_FD   = 4'b1100;

    function automatic logic [13:0] ex(input logic [3:0] st, input logic [2:0] fl,
                                       input logic fad, input logic fbd,
                                       input logic [1:0] fae, input logic [1:0] fbe,
                                       input logic err);
        return {st, fl, fad, fbd, fae, fbe, err};
    endfunction

    task automatic clear_in();
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; MemtoRegM = 0;
        BranchD = 0; PCSrcD = 0; MemAccessM = 0; mem_ready = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            clear_in();
            if (c == 0) begin
                rst = 1; RegWriteM = 1; WriteRegM = 8; RsE = 8; RsD = 8;
                MemAccessM = 1; MemtoRegE = 1; RtE = 3; RtD = 3; PCSrcD = 1;
                sb.push_back('{v: ex(S_NONE, 3'b000, 0, 0, 2'b00, 2'b00, 0), tag: "reset_hold"});
            end else begin
                rst = 0;
                sb.push_back('{v: ex(S_NONE, 3'b000, 0, 0, 2'b00, 2'b00, 0), tag: "reset_release"});
            end
            #2;
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.tag, obs, e.v);
            end
`ifdef HAZ_PERF_EN
            n_chk++;
            if (perf_stall_cyc !== 32'd0 || perf_flush_cnt !== 32'd0) begin
                n_fail++;
                $display("FAIL perf_reset: got %0d/%0d expected 0/0", perf_stall_cyc, perf_flush_cnt);
            end
`endif
        end
    endtask

    task automatic test_forward();
        exp_t e;
        logic [13:0] v;
        string t;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            clear_in();
            case (c)
                0: begin
                    RegWriteM = 1; WriteRegM = 8; RsE = 8; RegWriteW = 1; WriteRegW = 8;
                    v = ex(S_NONE, 3'b000, 0, 0, 2'b10, 2'b00, 0); t = "fwd_mem_prio";
                end
                1: begin
                    RegWriteM = 1; WriteRegM = 5; RegWriteW = 1; WriteRegW = 8; RsE = 8; RtE = 3;
                    v = ex(S_NONE, 3'b000, 0, 0, 2'b01, 2'b00, 0); t = "fwd_wb";
                end
                2: begin
                    RegWriteM = 1; RegWriteW = 1;
                    v = ex(S_NONE, 3'b000, 0, 0, 2'b00, 2'b00, 0); t = "fwd_zero_reg";
                end
                3: begin
                    RegWriteM = 1; WriteRegM = 7; RsD = 7; RtD = 7; RtE = 7;
                    RegWriteW = 1; WriteRegW = 2; RsE = 2;
                    v = ex(S_NONE, 3'b000, 1, 1, 2'b01, 2'b10, 0); t = "fwd_mixed";
                end
                4: begin
                    WriteRegM = 7; RsE = 7; RtE = 7; RsD = 7;
                    v = ex(S_NONE, 3'b000, 0, 0, 2'b00, 2'b00, 0); t = "fwd_no_write";
                end
                default: begin
                    RegWriteM = 1; WriteRegM = 9; RsE = 9; RtE = 9; RtD = 9;
                    RegWriteW = 1; WriteRegW = 9;
                    v = ex(S_NONE, 3'b000, 0, 1, 2'b10, 2'b10, 0); t = "fwd_both_mem";
                end
            endcase
            sb.push_back('{v: v, tag: t});
            #2;
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        logic [13:0] v;
        string t;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            clear_in();
            case (c)
                0: begin
                    MemtoRegE = 1; RtE = 9; RsD = 9;
                    v = ex(S_FD, 3'b010, 0, 0, 2'b00, 2'b00, 0); t = "lw_rs";
                end
                1: begin
                    v = ex(S_NONE, 3'b000, 0, 0, 2'b00, 2'b00, 0); t = "lw_clear";
                end
                2: begin
                    MemtoRegE = 1; RtE = 12; RtD = 12; RsD = 3;
                    v = ex(S_FD, 3'b010, 0, 0, 2'b00, 2'b00, 0); t = "lw_rt";
                end
                3: begin
                    MemtoRegE = 1; RtE = 12; RsD = 3; RtD = 4;
                    v = ex(S_NONE, 3'b000, 0, 0, 2'b00, 2'b00, 0); t = "lw_no_match";
                end
                default: begin
                    MemtoRegE = 1; RtE = 9; RsD = 9; PCSrcD = 1;
                    v = ex(S_FD, 3'b010, 0, 0, 2'b00, 2'b00, 0); t = "lw_over_pcsrc";
                end
            endcase
            sb.push_back('{v: v, tag: t});
            #2;
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic test_branch();
        exp_t e;
        logic [13:0] v;
        string t;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            clear_in();
            case (c)
                0: begin
                    BranchD = 1; RegWriteE = 1; WriteRegE = 4; RtD = 4;
                    v = ex(S_FD, 3'b010, 0, 0, 2'b00, 2'b00, 0); t = "br_exe_dep";
                end
                1: begin
                    BranchD = 1; PCSrcD = 1;
                    v = ex(S_NONE, 3'b100, 0, 0, 2'b00, 2'b00, 0); t = "br_taken";
                end
                2: begin
                    BranchD = 1; MemtoRegM = 1; WriteRegM = 6; RsD = 6;
                    v = ex(S_FD, 3'b010, 0, 0, 2'b00, 2'b00, 0); t = "br_mem_load";
                end
                3: begin
                    BranchD = 1; RegWriteE = 1; WriteRegE = 0;
                    v = ex(S_NONE, 3'b000, 0, 0, 2'b00, 2'b00, 0); t = "br_zero_reg";
                end
                default: begin
                    RegWriteE = 1; WriteRegE = 4; RtD = 4;
                    v = ex(S_NONE, 3'b000, 0, 0, 2'b00, 2'b00, 0); t = "br_not_branch";
                end
            endcase
            sb.push_back('{v: v, tag: t});
            #2;
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic test_mem_wait();
        exp_t e;
        logic [13:0] v;
        string t;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            clear_in();
            if (c < 3) begin
                MemAccessM = 1;
                if (c == 1) begin
                    MemtoRegE = 1; RtE = 9; RsD = 9; PCSrcD = 1;
                end
                v = ex(S_ALL, 3'b001, 0, 0, 2'b00, 2'b00, 0);
                t = (c == 1) ? "mem_over_hazard" : "mem_wait";
            end else if (c == 3) begin
                MemAccessM = 1; mem_ready = 1;
                v = ex(S_NONE, 3'b000, 0, 0, 2'b00, 2'b00, 0); t = "mem_ready";
            end else begin
                v = ex(S_NONE, 3'b000, 0, 0, 2'b00, 2'b00, 0); t = "mem_done";
            end
            sb.push_back('{v: v, tag: t});
            #2;
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [13:0] v;
        string t;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            clear_in();
            MemAccessM = (c < 5);
            mem_ready  = (c == 1) || (c == 3) || (c == 4);
            if (MemAccessM && !mem_ready) begin
                v = ex(S_ALL, 3'b001, 0, 0, 2'b00, 2'b00, 0); t = "b2b_stall";
            end else begin
                v = ex(S_NONE, 3'b000, 0, 0, 2'b00, 2'b00, 0); t = "b2b_free";
            end
            sb.push_back('{v: v, tag: t});
            #2;
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        logic [13:0] v;
        string t;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            clear_in();
            if (c < 15) begin
                MemAccessM = 1;
                v = ex(S_ALL, 3'b001, 0, 0, 2'b00, 2'b00, 0); t = "tmo_wait";
            end else if (c == 15) begin
                MemAccessM = 1; PCSrcD = 1;
                v = ex(S_NONE, 3'b001, 0, 0, 2'b00, 2'b00, 0); t = "tmo_abort";
            end else begin
                v = ex(S_NONE, 3'b000, 0, 0, 2'b00, 2'b00, 1); t = "tmo_err_sticky";
            end
            sb.push_back('{v: v, tag: t});
            #2;
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s[%0d]: got %b expected %b", e.tag, c, obs, e.v);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        exp_t e;
        logic [13:0] v;
        string t;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            clear_in();
            rst = (c == 2) || (c == 3);
            case (c)
                0, 1: begin
                    MemAccessM = 1;
                    v = ex(S_ALL, 3'b001, 0, 0, 2'b00, 2'b00, 1); t = "rmw_wait";
                end
                2: begin
                    MemAccessM = 1; RegWriteM = 1; WriteRegM = 8; RsE = 8;
                    v = ex(S_NONE, 3'b000, 0, 0, 2'b00, 2'b00, 1); t = "rmw_rst_first";
                end
                3: begin
                    MemAccessM = 1;
                    v = ex(S_NONE, 3'b000, 0, 0, 2'b00, 2'b00, 0); t = "rmw_rst_clear";
                end
                4: begin
                    v = ex(S_NONE, 3'b000, 0, 0, 2'b00, 2'b00, 0); t = "rmw_release";
                end
                5: begin
                    MemAccessM = 1;
                    v = ex(S_ALL, 3'b001, 0, 0, 2'b00, 2'b00, 0); t = "rmw_new_access";
                end
                6: begin
                    MemAccessM = 1; mem_ready = 1;
                    v = ex(S_NONE, 3'b000, 0, 0, 2'b00, 2'b00, 0); t = "rmw_new_ready";
                end
                default: begin
                    v = ex(S_NONE, 3'b000, 0, 0, 2'b00, 2'b00, 0); t = "rmw_idle";
                end
            endcase
            sb.push_back('{v: v, tag: t});
            #2;
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.tag, obs, e.v);
            end
`ifdef HAZ_PERF_EN
            if (c == 3 || c == 4 || c == 6) begin
                n_chk++;
                if (perf_stall_cyc !== ((c == 6) ? 32'd1 : 32'd0) || perf_flush_cnt !== 32'd0) begin
                    n_fail++;
                    $display("FAIL perf_after_rst[%0d]: got %0d/%0d expected %0d/0",
                             c, perf_stall_cyc, perf_flush_cnt, (c == 6) ? 1 : 0);
                end
            end
`endif
        end
    endtask

    initial begin
        rst = 1;
        clear_in();
        repeat (2) @(negedge clk);
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and stall controller for the 5-stage pipeline. It drives stall and flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers, and forwarding selects for the D and E stages. It also sequences variable-latency data-memory accesses through a wait-state FSM with timeout. All outputs feed the stage registers and the forwarding muxes.

Parameters:
MEM_TIMEOUT, 15, maximum consecutive memory-wait stall cycles before abort (must be ≥1)
CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
RsD, RtD  in  5  source registers in Decode
RsE, RtE  in  5  source registers in Execute
WriteRegE, WriteRegM, WriteRegW  in  5  destination registers per stage
RegWriteE, RegWriteM, RegWriteW  in  1  register-write controls per stage
MemtoRegE, MemtoRegM  in  1  load-in-stage flags
BranchD  in  1  branch being resolved in Decode
PCSrcD  in  1  branch taken
MemAccessM  in  1  load/store in Memory stage
mem_ready  in  1  data memory completes access this cycle
StallF, StallD, StallE, StallM  out  1  hold the PC / the named stage register
FlushD, FlushE, FlushW  out  1  clear IF/ID, ID/EX, MEM/WB (bubble)
ForwardAD, ForwardBD  out  1  Decode comparator forward from ALUOutM
ForwardAE, ForwardBE  out  2  Execute operand select
mem_err  out  1  sticky memory-timeout flag

Behaviour:
- Register 0 never matches. Every match term requires WriteReg* != 0.
- Forwarding (combinational):
  - ForwardAE = 2'b10 if RegWriteM & WriteRegM==RsE; else 2'b01 if RegWriteW & WriteRegW==RsE; else 2'b00. MEM has priority over WB.
  - ForwardBE: same rule using RtE.
  - ForwardAD = RegWriteM & WriteRegM==RsD. ForwardBD: same rule using RtD.
- lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
- brstall = BranchD & ((RegWriteE & (WriteRegE==RsD | WriteRegE==RtD)) | (MemtoRegM & (WriteRegM==RsD | WriteRegM==RtD))).
- memstall = MemAccessM & ~mem_ready & ~tmo, where tmo = (state==MWAIT & wait_cnt==MEM_TIMEOUT).
- Output priority, highest first:
  - memstall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. lwstall/brstall/PCSrcD are ignored that cycle.
  - tmo: no stalls, FlushW=1 so the aborted access is not written back.
  - lwstall|brstall: StallF=StallD=1, FlushE=1, StallE=StallM=0.
  - PCSrcD (no stall): FlushD=1.
  - Otherwise all stall and flush outputs are 0.
- FSM states RUN, MWAIT:
  - RUN: if memstall, go to MWAIT with wait_cnt←1; else stay with wait_cnt←0.
  - MWAIT: if mem_ready, go to RUN with wait_cnt←0; the stall drops in the same cycle mem_ready is high.
  - MWAIT: if tmo, go to RUN with wait_cnt←0 and mem_err←1.
  - MWAIT, otherwise: wait_cnt←wait_cnt+1.
  - MWAIT with MemAccessM=0 (defensive): go to RUN.
- Maximum consecutive stalled cycles per access = MEM_TIMEOUT.
- mem_err is sticky and is cleared only by rst.
- Reset: state←RUN, wait_cnt←0, mem_err←0. While rst=1, all stall, flush and forward outputs are forced to 0.
- Reset mid-wait: the FSM returns to RUN on the next edge with no mem_err.
- Latency: all stall/flush/forward outputs are combinational from inputs and state (0 cycles).

Optional Feature:
HAZ_PERF_EN
- Defined: adds outputs perf_stall_cyc[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cyc increments on any cycle with StallF=1.
  - perf_flush_cnt increments on any cycle with FlushD|FlushE.
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Package pipe_ctrl_pkg:
  - forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - FSM state typedef (RUN, MWAIT)
  - REG_ZERO=5'd0
- One sub-module, pipe_fwd_unit: purely combinational ForwardAE/BE/AD/BD generation. The top module holds hazard detection, priority and the FSM.

Test Plan:
- RegWriteM=1, WriteRegM=5'd8, RsE=8, RegWriteW=1, WriteRegW=8 → ForwardAE=2'b10 (MEM wins). With WriteRegM=0, RsE=0 → ForwardAE=2'b00.
- Load-use: MemtoRegE=1, RtE=9, RsD=9 → StallF=StallD=FlushE=1, StallE=0 for exactly 1 cycle, then all 0.
- Branch hazard: BranchD=1, RegWriteE=1, WriteRegE=4, RtD=4 → StallF=StallD=FlushE=1. When cleared with PCSrcD=1 → FlushD=1, no stalls.
- Memory wait: MemAccessM=1, mem_ready low for 3 cycles then high → StallF..StallM=1 and FlushW=1 for 3 cycles, 0 in the ready cycle, FSM back in RUN, mem_err=0.
- Timeout (MEM_TIMEOUT=15): mem_ready held low → 15 stall cycles, then 1 cycle with no stall and FlushW=1, mem_err=1 and held until rst.
- rst asserted during MWAIT, then released with MemAccessM=0 → outputs 0 during rst, state RUN, wait_cnt=0, mem_err=0. Under HAZ_PERF_EN, both counters read 0.
